// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency fetch pipeline feeding a 4-entry response FIFO,
// with credit-based request flow control, flush on redirect and a program-load write port.
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_instr,
    output logic [31:0] o_rsp_addr,
    output logic        o_rsp_err,
    input  logic        i_flush,
    input  logic        i_ld_en,
    input  logic [31:0] i_ld_addr,
    input  logic [31:0] i_ld_data
);
    localparam int unsigned AW  = $clog2(DEPTH_WORDS);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] mem [DEPTH_WORDS];

    logic        req_fire;
    logic        rsp_pop;
    logic        req_err;
    logic [31:0] req_instr;
    logic [2:0]  inflight;
    logic [3:0]  credit_used;
    logic        push_vld;
    logic [31:0] push_instr;
    logic [31:0] push_addr;
    logic        push_err;

    logic [1:0]  wptr_q, rptr_q;
    logic [2:0]  count_q;
    logic [31:0] f_instr_q [4];
    logic [31:0] f_addr_q  [4];
    logic [3:0]  f_err_q;

    logic        unused_ld;
    assign unused_ld = ^{i_ld_addr[31:AW+2], i_ld_addr[1:0]};

    assign req_err   = (i_req_addr[1:0] != 2'b00) || ({2'b00, i_req_addr[31:2]} >= DEPTH_WORDS);
    assign req_instr = req_err ? NOP : mem[i_req_addr[AW+1:2]];

    // Every accepted request holds a credit until popped, so a FIFO slot is always waiting for it.
    assign credit_used = {1'b0, inflight} + {1'b0, count_q};
    assign o_req_ready = i_reset && !i_flush && (credit_used < 4'd4);
    assign req_fire    = i_req_valid && o_req_ready;
    assign rsp_pop     = o_rsp_valid && i_rsp_ready;

    // Read data is captured at the same edge as the load write, giving read-before-write.
    always_ff @(posedge i_clk) begin
        if (i_ld_en) begin
            mem[i_ld_addr[AW+1:2]] <= i_ld_data;
        end
    end

    if (LATENCY == 1) begin : g_direct
        assign push_vld   = req_fire;
        assign push_instr = req_instr;
        assign push_addr  = i_req_addr;
        assign push_err   = req_err;
        assign inflight   = 3'd0;
    end else begin : g_pipe
        localparam int unsigned N = LATENCY - 1;

        logic [N-1:0] vld_q;
        logic [N-1:0] err_q;
        logic [31:0]  instr_q [N];
        logic [31:0]  addr_q  [N];

        always_ff @(posedge i_clk or negedge i_reset) begin
            if (!i_reset) begin
                vld_q <= '0;
                err_q <= '0;
                for (int i = 0; i < N; i++) begin
                    instr_q[i] <= '0;
                    addr_q[i]  <= '0;
                end
            end else begin
                vld_q[0]   <= req_fire;
                err_q[0]   <= req_err;
                instr_q[0] <= req_instr;
                addr_q[0]  <= i_req_addr;
                for (int i = 1; i < N; i++) begin
                    vld_q[i]   <= vld_q[i-1];
                    err_q[i]   <= err_q[i-1];
                    instr_q[i] <= instr_q[i-1];
                    addr_q[i]  <= addr_q[i-1];
                end
                if (i_flush) begin
                    vld_q <= '0;
                end
            end
        end

        always_comb begin
            inflight = 3'd0;
            for (int i = 0; i < N; i++) begin
                inflight = inflight + 3'(vld_q[i]);
            end
        end

        assign push_vld   = vld_q[N-1];
        assign push_instr = instr_q[N-1];
        assign push_addr  = addr_q[N-1];
        assign push_err   = err_q[N-1];
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wptr_q  <= 2'd0;
            rptr_q  <= 2'd0;
            count_q <= 3'd0;
            f_err_q <= '0;
            for (int i = 0; i < 4; i++) begin
                f_instr_q[i] <= '0;
                f_addr_q[i]  <= '0;
            end
        end else if (i_flush) begin
            wptr_q  <= 2'd0;
            rptr_q  <= 2'd0;
            count_q <= 3'd0;
        end else begin
            if (push_vld) begin
                f_instr_q[wptr_q] <= push_instr;
                f_addr_q[wptr_q]  <= push_addr;
                f_err_q[wptr_q]   <= push_err;
                wptr_q            <= wptr_q + 2'd1;
            end
            if (rsp_pop) begin
                rptr_q <= rptr_q + 2'd1;
            end
            case ({push_vld, rsp_pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign o_rsp_valid = (count_q != 3'd0);
    assign o_rsp_instr = f_instr_q[rptr_q];
    assign o_rsp_addr  = f_addr_q[rptr_q];
    assign o_rsp_err   = f_err_q[rptr_q];

    a_no_push_full: assert property (@(posedge i_clk) disable iff (!i_reset)
        !(push_vld && !i_flush && count_q == 3'd4));
    a_no_pop_empty: assert property (@(posedge i_clk) disable iff (!i_reset)
        !(rsp_pop && count_q == 3'd0));

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: LATENCY=2 instance carries the main tests, LATENCY=1 and 4
// instances share the same stimulus for the latency and mid-stream reset checks.
module tb_imem_responder;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, rsp_ready, flush, ld_en;
    logic [31:0] req_addr, ld_addr, ld_data;

    logic [2:0]  rdy, vld, errv;
    logic [31:0] ins [3];
    logic [31:0] ad  [3];

    int total = 0;
    int bad   = 0;

    logic [31:0] words [5];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    imem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (
        .i_clk(clk), .i_reset(rstn), .i_req_valid(req_valid), .o_req_ready(rdy[0]),
        .i_req_addr(req_addr), .o_rsp_valid(vld[0]), .i_rsp_ready(rsp_ready),
        .o_rsp_instr(ins[0]), .o_rsp_addr(ad[0]), .o_rsp_err(errv[0]), .i_flush(flush),
        .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_data(ld_data)
    );
    imem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_l2 (
        .i_clk(clk), .i_reset(rstn), .i_req_valid(req_valid), .o_req_ready(rdy[1]),
        .i_req_addr(req_addr), .o_rsp_valid(vld[1]), .i_rsp_ready(rsp_ready),
        .o_rsp_instr(ins[1]), .o_rsp_addr(ad[1]), .o_rsp_err(errv[1]), .i_flush(flush),
        .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_data(ld_data)
    );
    imem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (
        .i_clk(clk), .i_reset(rstn), .i_req_valid(req_valid), .o_req_ready(rdy[2]),
        .i_req_addr(req_addr), .o_rsp_valid(vld[2]), .i_rsp_ready(rsp_ready),
        .o_rsp_instr(ins[2]), .o_rsp_addr(ad[2]), .o_rsp_err(errv[2]), .i_flush(flush),
        .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_data(ld_data)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single fetch on the LATENCY=2 instance; expects an empty FIFO and rsp_ready high.
    task automatic fetch_one(input logic [31:0] a, input logic [31:0] exp_i, input logic exp_e,
                             input string nm);
        int n;
        req_valid = 1'b1;
        req_addr  = a;
        #1 chk({nm, " ready"}, 32'(rdy[1]), 32'd1);
        step();
        req_valid = 1'b0;
        ld_en     = 1'b0;
        n = 0;
        #1;
        while (!vld[1] && n < 10) begin
            step();
            #1;
            n++;
        end
        chk({nm, " latency"}, 32'(n), 32'd1);
        chk({nm, " instr"}, ins[1], exp_i);
        chk({nm, " addr"}, ad[1], a);
        chk({nm, " err"}, 32'(errv[1]), 32'(exp_e));
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int acc;
        int stale;
        int first [3];
        int exp_first [3];

        words[0] = 32'h0050_0093;
        words[1] = 32'h00A0_0113;
        words[2] = 32'h0020_81B3;
        words[3] = 32'h0000_006F;
        words[4] = 32'h0000_0513;
        vecs[0] = '{32'h0000_0006, NOP, 1'b1};
        vecs[1] = '{32'h0000_1000, NOP, 1'b1};
        vecs[2] = '{32'h0000_0000, 32'h0050_0093, 1'b0};
        vecs[3] = '{32'h0000_0008, 32'h0020_81B3, 1'b0};
        vecs[4] = '{32'hFFFF_FFFC, NOP, 1'b1};
        vecs[5] = '{32'h0000_000C, 32'h0000_006F, 1'b0};
        exp_first = '{1, 2, 4};

        rstn = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; flush = 1'b0; ld_en = 1'b0;
        req_addr = '0; ld_addr = '0; ld_data = '0;
        #1;
        chk("reset ready", 32'(rdy[1]), 32'd0);
        chk("reset valid", 32'(vld[1]), 32'd0);
        chk("reset instr", ins[1], 32'd0);
        chk("reset addr", ad[1], 32'd0);
        chk("reset err", 32'(errv[1]), 32'd0);
        step();
        step();
        rstn = 1'b1;
        #1 chk("release ready", 32'(rdy[1]), 32'd1);

        for (int i = 0; i < 5; i++) begin
            ld_en = 1'b1; ld_addr = 32'(4 * i); ld_data = words[i];
            step();
        end
        ld_en = 1'b0;

        // Back-to-back stream: first response two cycles after first acceptance.
        rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            req_valid = (c < 4);
            req_addr  = 32'(4 * c);
            #1;
            if (c < 4) chk("stream ready", 32'(rdy[1]), 32'd1);
            chk("stream valid", 32'(vld[1]), 32'((c >= 2) && (c <= 5)));
            if (c >= 2 && c <= 5) begin
                chk("stream instr", ins[1], words[c-2]);
                chk("stream addr", ad[1], 32'(4 * (c - 2)));
            end
            step();
        end
        req_valid = 1'b0;

        // Back-pressure: exactly four acceptances, ready returns after the first pop.
        rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            req_valid = 1'b1;
            req_addr  = 32'(4 * (c % 4));
            #1;
            acc += int'(rdy[1]);
            chk("bp ready", 32'(rdy[1]), 32'(c < 4));
            step();
        end
        req_valid = 1'b0;
        chk("bp accepted", 32'(acc), 32'd4);
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp valid", 32'(vld[1]), 32'd1);
            chk("bp instr", ins[1], words[k]);
            chk("bp addr", ad[1], 32'(4 * k));
            chk("bp ready after pop", 32'(rdy[1]), 32'(k > 0));
            step();
        end
        #1 chk("bp drained", 32'(vld[1]), 32'd0);

        for (int v = 0; v < 6; v++) begin
            fetch_one(vecs[v].addr, vecs[v].instr, vecs[v].err, $sformatf("vec%0d", v));
        end

        // Flush with three requests outstanding.
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            req_valid = 1'b1;
            req_addr  = 32'(4 * c);
            #1 chk("flush pre ready", 32'(rdy[1]), 32'd1);
            step();
        end
        flush = 1'b1;
        req_addr = 32'hC;
        #1 chk("flush cycle ready", 32'(rdy[1]), 32'd0);
        step();
        flush = 1'b0;
        req_valid = 1'b0;
        #1 chk("flush next valid", 32'(vld[1]), 32'd0);
        rsp_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            #1 stale += int'(vld[1]);
        end
        chk("flush stale", 32'(stale), 32'd0);
        fetch_one(32'h8, words[2], 1'b0, "post flush");

        ld_en = 1'b1; ld_addr = 32'h10; ld_data = 32'hDEAD_BEEF;
        fetch_one(32'h10, words[4], 1'b0, "collide old");
        fetch_one(32'h10, 32'hDEAD_BEEF, 1'b0, "collide new");

        // Latency per instance.
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        first = '{-1, -1, -1};
        for (int c = 0; c < 8; c++) begin
            req_valid = (c == 0);
            req_addr  = 32'h0;
            #1;
            for (int i = 0; i < 3; i++) begin
                if (vld[i] && first[i] < 0) begin
                    first[i] = c;
                    chk($sformatf("lat inst%0d instr", i), ins[i], words[0]);
                end
            end
            step();
        end
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("lat inst%0d cycles", i), 32'(first[i]), 32'(exp_first[i]));
        end

        // Reset mid-stream with requests both in flight and buffered.
        rsp_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            req_valid = 1'b1;
            req_addr  = 32'(4 * c);
            #1;
            for (int i = 0; i < 3; i++) chk($sformatf("mid inst%0d ready", i), 32'(rdy[i]), 32'd1);
            step();
        end
        req_valid = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("mid inst%0d valid", i), 32'(vld[i]), 32'd1);
        rstn = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("async inst%0d valid", i), 32'(vld[i]), 32'd0);
            chk($sformatf("async inst%0d instr", i), ins[i], 32'd0);
            chk($sformatf("async inst%0d addr", i), ad[i], 32'd0);
            chk($sformatf("async inst%0d err", i), 32'(errv[i]), 32'd0);
            chk($sformatf("async inst%0d ready", i), 32'(rdy[i]), 32'd0);
        end
        step();
        step();
        rstn = 1'b1;
        rsp_ready = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("rel inst%0d ready", i), 32'(rdy[i]), 32'd1);
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            #1 stale += int'(vld[0]) + int'(vld[1]) + int'(vld[2]);
        end
        chk("reset stale", 32'(stale), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
